// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//
// Oversampling UART receiver. Deserializes an asynchronous serial line
// (8N1, LSB first) into a 9-bit word {err, byte[7:0]} and presents it to the
// downstream load register together with a single-cycle load strobe.
//
// Optional feature: define RX_PARITY_EN to add an even-parity bit between the
// last data bit and the stop bit (11-bit frame). RX_data[8] then reports
// framing_err | parity_err. Without the macro only 8N1 is supported and no
// parity state or parity flop is built.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//   CNT_W         width of the bit-timing counter; must hold CLKS_PER_BIT-1
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   RX_in    in   1  raw serial line, idle high, asynchronous to clk
//   RX_data  out  9  {err, byte}; updated only together with load, held otherwise
//   load     out  1  one-cycle strobe: RX_data holds a new word this cycle
//   busy     out  1  high from start-bit confirmation until return to IDLE
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 18,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX_in,
    output logic [8:0] RX_data,
    output logic       load,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd6;
`endif

    // Counter values at which the line is sampled: middle of the start bit,
    // then one full bit time later for every following bit (mid-bit).
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Two-flop synchronizer; only its output rx_s is seen by the FSM.
    logic [1:0]       sync_q,     sync_d;
    logic             rx_s;

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       idx_q,      idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic             stop_bit_q, stop_bit_d;
    logic [8:0]       rx_data_q,  rx_data_d;
    logic             load_q,     load_d;
    logic             busy_q,     busy_d;
    logic             err_bit;
`ifdef RX_PARITY_EN
    logic             par_err_q,  par_err_d;
`endif

    assign rx_s = sync_q[1];

    // Error flag reported with the word: missing stop bit, plus bad parity
    // when the parity bit is part of the frame.
    always_comb begin
        err_bit = ~stop_bit_q;
`ifdef RX_PARITY_EN
        err_bit = err_bit | par_err_q;
`endif
    end

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        sync_d     = {sync_q[0], RX_in};
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        stop_bit_d = stop_bit_q;
        rx_data_d  = rx_data_q;
        load_d     = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d  = par_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    // Still low at mid start bit: a real start bit. A high
                    // line here means the low pulse was a glitch.
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    // Even parity: data plus parity bit must hold an even
                    // number of ones.
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    stop_bit_d = rx_s;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                // Publish the word. Leaving DONE right away puts the FSM
                // back in IDLE while load is high, so a start bit that
                // directly follows a good stop bit is still caught.
                load_d    = 1'b1;
                rx_data_d = {err_bit, shift_q};
                state_d   = stop_bit_q ? ST_IDLE : ST_BREAK;
            end

            ST_BREAK: begin
                // Line held low past the stop bit: wait for it to return
                // high rather than decoding the low level as a new frame.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_START);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            stop_bit_q <= 1'b1;
            rx_data_q  <= 9'h000;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            stop_bit_q <= stop_bit_d;
            rx_data_q  <= rx_data_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
`ifdef RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign RX_data = rx_data_q;
    assign load    = load_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Self-checking bench for uart_rx_deserializer (CLKS_PER_BIT=18, 10 ns clk).
// A table of frames plus hand-written break / glitch / mid-frame-reset
// sequences, followed by random frames. Expected words come from the frame
// rules ({~stop | parity_err, byte}); a monitor pairs every load pulse with
// the oldest expected word and checks data and latency.
// Define RX_PARITY_EN for both bench and RTL to exercise the parity build.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int C = 18;
`ifdef RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Rising edges from the first edge that sees the low start bit on the
    // pin to the edge at which load goes high.
    localparam int LAT = 2 + C / 2 + 9 * C + 1 + (PAR ? C : 0);

    typedef struct {
        logic [7:0] data;
        logic       par_flip;  // 1: send the wrong parity bit
        logic       stop;
        int         gap;       // idle cycles after the frame
        logic [8:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [8:0] rx_data;
    logic       load;
    logic       busy;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(C),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .RX_in  (rx_in),
        .RX_data(rx_data),
        .load   (load),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int         checks   = 0;
    int         errors   = 0;
    int         load_cnt = 0;
    logic       prev_load = 1'b0;
    logic [8:0] exp_data_q[$];
    int         exp_fall_q[$];
    logic [8:0] mon_exp;
    int         mon_fall;
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: word the receiver must deliver for a given frame.
    function automatic logic [8:0] model(input logic [7:0] d, input logic par_bit,
                                         input logic stop);
        logic err;
        err = !stop;
        if (PAR) err = err | (^{d, par_bit});
        return {err, d};
    endfunction

    // Load monitor: every pulse must be single-cycle, expected, carry the
    // expected word and arrive at the expected latency.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            check("load_single_cycle", prev_load, 0);
            check("load_expected", exp_data_q.size() != 0, 1);
            if (exp_data_q.size() != 0) begin
                mon_exp  = exp_data_q.pop_front();
                mon_fall = exp_fall_q.pop_front();
                check("rx_data", rx_data, mon_exp);
                check("load_latency", cycle - mon_fall, LAT);
            end
        end
        prev_load = load;
    end

    // Register an expected word for a frame whose start bit is driven now
    // (called at a falling clk edge; the next rising edge sees the low).
    task automatic expect_word(input logic [8:0] w);
        exp_data_q.push_back(w);
        exp_fall_q.push_back(cycle + 1);
    endtask

    // Drive start, data, optional parity and stop bit; line is left at the
    // stop-bit level. Must be called at a falling clk edge.
    task automatic drive_bits(input logic [7:0] d, input logic par_bit, input logic stop);
        rx_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (i == 4) begin
                repeat (C / 2) @(negedge clk);
                check("busy_mid_frame", busy, 1);
                repeat (C - C / 2) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        if (PAR) begin
            rx_in = par_bit;
            repeat (C) @(negedge clk);
        end
        rx_in = stop;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop,
                              input logic [8:0] w, input int gap);
        expect_word(w);
        drive_bits(d, par_bit, stop);
        // The word is due before the stop bit ends.
        check("load_before_frame_end", exp_data_q.size(), 0);
        exp_data_q.delete();
        exp_fall_q.delete();
        rx_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic add_vec(input logic [7:0] d, input logic flip, input logic stop,
                           input int gap, input logic [8:0] w);
        vec_t v;
        v.data     = d;
        v.par_flip = flip;
        v.stop     = stop;
        v.gap      = gap;
        v.exp      = w;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [7:0] d;
        logic       stop;
        logic       pbit;
        int         gap;

        // Frame table: byte, wrong-parity, stop bit, gap after, expected word.
        add_vec(8'h54, 1'b0, 1'b1, 20, 9'h054);
        add_vec(8'h54, 1'b0, 1'b1,  0, 9'h054);  // back-to-back with next
        add_vec(8'h2C, 1'b0, 1'b1, 20, 9'h02C);
        add_vec(8'hFF, 1'b0, 1'b1,  5, 9'h0FF);
        add_vec(8'h00, 1'b0, 1'b1,  0, 9'h000);
        add_vec(8'h80, 1'b0, 1'b1,  7, 9'h080);
        add_vec(8'hA5, 1'b0, 1'b0, 10, 9'h1A5);  // framing error, short low
        add_vec(8'h01, 1'b0, 1'b1,  3, 9'h001);
`ifdef RX_PARITY_EN
        // 0x54 has three ones: even-parity bit 1 is correct, 0 is wrong.
        add_vec(8'h54, 1'b1, 1'b1, 10, 9'h154);
        add_vec(8'h54, 1'b0, 1'b1, 10, 9'h054);
`endif

        // Reset state.
        rst   = 1'b1;
        rx_in = 1'b1;
        #20;
        check("reset_rx_data", rx_data, 9'h000);
        check("reset_load", load, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_rx_data", rx_data, 9'h000);
        check("idle_busy", busy, 0);
        check("idle_no_load", load_cnt, 0);

        // Short low glitch: rejected, never busy, no load.
        base  = load_cnt;
        rx_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("glitch_busy_low", busy, 0);
        end
        rx_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 4) check("glitch_busy_after", busy, 0);
        end
        check("glitch_no_load", load_cnt, base);

        // Table-driven frames.
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, (^vecs[i].data) ^ vecs[i].par_flip, vecs[i].stop,
                       vecs[i].exp, vecs[i].gap);
        end

        // Break: stop bit 0 and line held low 40 more clks.
        base = load_cnt;
        expect_word(9'h1A5);
        drive_bits(8'hA5, ^8'hA5, 1'b0);
        check("break_loaded", exp_data_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(negedge clk);
            check("break_busy_high", busy, 1);
        end
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_released", busy, 0);
        check("break_single_load", load_cnt, base + 1);
        repeat (10) @(negedge clk);

        // Reset during data bit 4 of 0x3C, then a clean 0x3C.
        base  = load_cnt;
        d     = 8'h3C;
        rx_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            repeat (C) @(negedge clk);
        end
        rx_in = d[4];
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_rx_data", rx_data, 9'h000);
        check("midreset_load", load, 0);
        check("midreset_busy", busy, 0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midreset_no_load", load_cnt, base);
        check("midreset_idle_busy", busy, 0);
        send_frame(8'h3C, ^8'h3C, 1'b1, 9'h03C, 10);

        // Random frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pbit = ^d;
            if (PAR && ($urandom_range(0, 3) == 0)) pbit = ~pbit;
            // After a missing stop bit the line must go high long enough
            // for the receiver to leave the break condition.
            gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(5, 12));
            send_frame(d, pbit, stop, model(d, pbit, stop), gap);
        end

        repeat (20) @(negedge clk);
        check("final_no_pending", exp_data_q.size(), 0);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
